// File: rtl/fpu_share_arbiter.sv
// rtl/fpu_share_arbiter.sv - round-robin sharing of one fixed-latency FPU among NUM_REQ requesters (optional FPU_ARB_STATS_EN adds per-requester grant counters)
module fpu_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*32-1:0]         req_opA,
    input  logic [NUM_REQ*32-1:0]         req_opB,
    input  logic [NUM_REQ*2-1:0]          req_op,
    output logic [31:0]                   fpu_opA,
    output logic [31:0]                   fpu_opB,
    output logic [1:0]                    fpu_op,
    input  logic [31:0]                   fpu_out,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [31:0]                   rsp_data,
    output logic                          busy
`ifdef FPU_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]         grant_cnt
`endif
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   cand;
    logic              found;
    logic              accept;

    // Round-robin pick: first asserted request after the last winner; grant only offered in IDLE
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        req_ready = '0;
        if (state == IDLE && found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);

    // Control FSM: accept one op, hold operands through the FPU latency, present the tagged result
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= ID_W'(NUM_REQ - 1);
            cnt       <= '0;
            fpu_opA   <= '0;
            fpu_opB   <= '0;
            fpu_op    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        fpu_opA <= req_opA[32*grant_idx +: 32];
                        fpu_opB <= req_opB[32*grant_idx +: 32];
                        fpu_op  <= req_op[2*grant_idx +: 2];
                        rr_ptr  <= grant_idx;
                        rsp_id  <= grant_idx;
                        cnt     <= CNT_W'(LATENCY - 1);
                        busy    <= 1'b1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        rsp_data  <= fpu_out;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FPU_ARB_STATS_EN
    // Saturating per-requester accept counters
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt <= '0;
        end else if (accept && (grant_cnt[16*grant_idx +: 16] != 16'hFFFF)) begin
            grant_cnt[16*grant_idx +: 16] <= grant_cnt[16*grant_idx +: 16] + 16'd1;
        end
    end
`endif

endmodule
